// File: rtl/md_unit.sv
// md_unit: Execute-stage multiply/divide unit with private HI/LO registers.
// Multi-cycle operations compute their 64-bit result at accept time into a
// pending register. The result is committed to HI/LO when the busy counter
// expires, so the latency is fixed and does not depend on the operands.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        madd,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic             pendWrite;
    logic [63:0]      result;
    logic signed [63:0] opA;
    logic signed [63:0] opB;
    logic signed [63:0] sProd;
    logic [63:0]      uProd;
    logic             isDiv;
    logic             divByZero;

    // Signed divide: {remainder, quotient}, truncating toward zero.
    // The one overflowing case is pinned explicitly so it does not depend on
    // the tool's handling of -2^31 / -1. Division by zero yields zero here;
    // that result is never committed.
    function automatic logic [63:0] divSigned(input logic [31:0] n, input logic [31:0] d);
        logic signed [31:0] sn;
        logic signed [31:0] sd;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sn = n;
        sd = d;
        if (d == 32'h0) begin
            return 64'h0;
        end
        if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            return {32'h0, 32'h8000_0000};
        end
        q = sn / sd;
        r = sn % sd;
        return {r, q};
    endfunction

    // Unsigned divide: {remainder, quotient}.
    function automatic logic [63:0] divUnsigned(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'h0) begin
            return 64'h0;
        end
        return {n % d, n / d};
    endfunction

    assign start  = mult | multu | div | divu | madd;
    assign md_out = mfhi ? hi : lo;

    assign isDiv     = div | divu;
    assign divByZero = isDiv && (b == 32'h0);

    // Operand extension and the signed/unsigned full-width products.
    always_comb begin
        opA   = {{32{a[31]}}, a};
        opB   = {{32{b[31]}}, b};
        sProd = opA * opB;
        uProd = {32'h0, a} * {32'h0, b};
    end

    // Select the 64-bit result of the operation being started.
    always_comb begin
        result = 64'h0;
        if (mult) begin
            result = sProd;
        end else if (multu) begin
            result = uProd;
        end else if (madd) begin
            result = {hi, lo} + sProd;
        end else if (div) begin
            result = divSigned(a, b);
        end else if (divu) begin
            result = divUnsigned(a, b);
        end
    end

    // Accept/busy sequencing, moves to HI/LO, and the commit at counter expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            busy      <= 1'b0;
            pendHi    <= 32'h0;
            pendLo    <= 32'h0;
            pendWrite <= 1'b0;
            hi        <= 32'h0;
            lo        <= 32'h0;
        end else if (!busy) begin
            if (start) begin
                pendHi    <= result[63:32];
                pendLo    <= result[31:0];
                pendWrite <= !divByZero;
                count     <= isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy      <= 1'b1;
            end else begin
                if (mthi) begin
                    hi <= a;
                end
                if (mtlo) begin
                    lo <= a;
                end
            end
        end else begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
                if (pendWrite) begin
                    hi <= pendHi;
                    lo <= pendLo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit with hand-computed results.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult, multu, div, divu, madd;
    logic        mthi, mtlo, mfhi, mflo;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo, md_out;

    int nChecks = 0;
    int nFails  = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .mult(mult), .multu(multu), .div(div), .divu(divu), .madd(madd),
        .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
        .a(a), .b(b),
        .start(start), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", nChecks);
        $fatal(1, "timeout");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        mult = 0; multu = 0; div = 0; divu = 0; madd = 0;
        mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
    endtask

    // op: 0 mult, 1 multu, 2 div, 3 divu, 4 madd
    task automatic runOp(input int op, input logic [31:0] av, input logic [31:0] bv,
                         input int expBusy, input string tag);
        int cycles;
        a = av;
        b = bv;
        case (op)
            0: mult  = 1;
            1: multu = 1;
            2: div   = 1;
            3: divu  = 1;
            default: madd = 1;
        endcase
        #1;
        checkVal({tag, "_start"}, 64'(start), 64'd1);
        nextCycle();
        clearStrobes();
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            nextCycle();
        end
        checkVal({tag, "_busycycles"}, 64'(cycles), 64'(expBusy));
    endtask

    task automatic moveOp(input logic toHi, input logic [31:0] val);
        a = val;
        if (toHi) mthi = 1; else mtlo = 1;
        nextCycle();
        clearStrobes();
    endtask

    initial begin
        int cycles;
        clearStrobes();
        a = 0;
        b = 0;
        reset = 1;
        nextCycle();
        nextCycle();
        reset = 0;
        checkVal("reset_busy", 64'(busy), 64'd0);
        checkVal("reset_hilo", {hi, lo}, 64'h0);
        checkVal("idle_start", 64'(start), 64'd0);

        runOp(0, 32'hFFFF_FFFD, 32'd5, 5, "mult");
        checkVal("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        runOp(1, 32'hFFFF_FFFF, 32'd2, 5, "multu");
        checkVal("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        runOp(2, 32'hFFFF_FFF9, 32'd2, 10, "div");
        checkVal("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        runOp(3, 32'd7, 32'd0, 10, "divu0");
        checkVal("divu0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        runOp(2, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf");
        checkVal("divovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        runOp(3, 32'd100, 32'd7, 10, "divu");
        checkVal("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        runOp(2, 32'd7, 32'hFFFF_FFFE, 10, "divneg");
        checkVal("divneg_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        moveOp(1'b1, 32'h1234_5678);
        checkVal("mthi_hi", 64'(hi), 64'h1234_5678);
        checkVal("mthi_busy", 64'(busy), 64'd0);
        mfhi = 1;
        #1;
        checkVal("mfhi_out", 64'(md_out), 64'h1234_5678);
        clearStrobes();

        moveOp(1'b1, 32'h0);
        moveOp(1'b0, 32'd10);
        mflo = 1;
        #1;
        checkVal("mtlo_mdout", 64'(md_out), 64'd10);
        clearStrobes();
        checkVal("moves_hilo", {hi, lo}, 64'h0000_0000_0000_000A);

        // madd with a mthi strobe injected on the second busy cycle
        a = 32'd3;
        b = 32'd4;
        madd = 1;
        nextCycle();
        clearStrobes();
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            if (cycles == 2) begin
                a = 32'hDEAD_BEEF;
                mthi = 1;
            end else begin
                mthi = 0;
            end
            nextCycle();
        end
        mthi = 0;
        checkVal("madd_busycycles", 64'(cycles), 64'd5);
        checkVal("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0016);
        mflo = 1;
        #1;
        checkVal("madd_mflo", 64'(md_out), 64'h16);
        mflo = 0;
        mfhi = 1;
        #1;
        checkVal("madd_mfhi", 64'(md_out), 64'h0);
        clearStrobes();

        runOp(4, 32'hFFFF_FFFF, 32'h17, 5, "maddneg");
        checkVal("maddneg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset during busy cycle 4 of a divide
        a = 32'd100;
        b = 32'd3;
        div = 1;
        nextCycle();
        clearStrobes();
        for (int i = 1; i < 4; i++) begin
            nextCycle();
        end
        checkVal("rst_midop_busy_before", 64'(busy), 64'd1);
        reset = 1;
        nextCycle();
        reset = 0;
        checkVal("rst_midop_busy", 64'(busy), 64'd0);
        checkVal("rst_midop_hilo", {hi, lo}, 64'h0);
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkVal("rst_nolate_hilo", {hi, lo}, 64'h0);
            checkVal("rst_nolate_busy", 64'(busy), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
